// File: rtl/osecpu_pkg.sv
// Shared definitions for the OSECPU-style integer core: opcodes, ALU selects,
// FSM state encoding, instruction field positions and the 7-segment font.
package osecpu_pkg;

  localparam int REG_COUNT = 64;
  localparam int REG_AW    = 6;
  localparam int DATA_W    = 32;

  localparam logic [7:0] OP_LIMM16 = 8'h02;
  localparam logic [7:0] OP_CP     = 8'hD2;
  localparam logic [7:0] OP_ADD    = 8'h14;
  localparam logic [7:0] OP_SUB    = 8'h15;
  localparam logic [7:0] OP_CPDR   = 8'hD3;
  localparam logic [7:0] OP_END    = 8'hF0;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd4;
  localparam logic [3:0] ALU_SUB  = 4'd5;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 24;
  localparam int OP0_MSB  = 23;
  localparam int OP0_LSB  = 18;
  localparam int OP1_MSB  = 17;
  localparam int OP1_LSB  = 12;
  localparam int OP2_MSB  = 11;
  localparam int OP2_LSB  = 6;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  // Active-low segments, bit0=a .. bit6=g, bit7=dp kept off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/osecpu_alu_controller.sv
// Combinational integer ALU; unknown selects produce zero, no flags.
module alu_controller
  import osecpu_pkg::*;
(
  input  logic [3:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/osecpu_integer_register.sv
// 64 x 32 integer register file: two combinational read ports, one write port,
// all entries cleared by synchronous reset.
module integer_register
  import osecpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see the value before this cycle's write lands.
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/osecpu_led7seg.sv
// Four-digit multiplexed 7-segment scanner; seg and segsel are registered
// together so the digit and its pattern always change on the same edge.
module led7seg
  import osecpu_pkg::*;
#(
  parameter int SCAN_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic [7:0]  seg,
  output logic [3:0]  segsel
);

  logic [SCAN_DIV+1:0] scan_cnt;
  logic [1:0]          digit;
  logic [3:0]          nibble;

  assign digit = scan_cnt[SCAN_DIV+1:SCAN_DIV];

  always_comb begin
    nibble = value[3:0];
    case (digit)
      2'd0: nibble = value[3:0];
      2'd1: nibble = value[7:4];
      2'd2: nibble = value[11:8];
      default: nibble = value[15:12];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      seg      <= 8'hFF;
      segsel   <= 4'hF;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      seg      <= hex_to_seg(nibble);
      segsel   <= ~(4'b0001 << digit);
    end
  end

endmodule

// File: rtl/osecpu_top.sv
// OSECPU-style integer core: two-cycle fetch/execute over external program
// memory, 64-entry register file, display register DR and 7-seg readout.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   FETCH | drive pc onto mem_addr, latch instruction word
//   EXEC  | execute latched instruction, commit writes, advance pc
module osecpu_top
  import osecpu_pkg::*;
#(
  parameter int SCAN_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  seg,
  output logic [3:0]  segsel,
  output logic        halted,
  output logic [31:0] dr
);

  state_t            state, state_nxt;
  logic [15:0]       pc, pc_nxt;
  logic [31:0]       instr, instr_nxt;
  logic [31:0]       dr_nxt;
  logic              halted_nxt;

  logic [7:0]        op;
  logic [REG_AW-1:0] op0, op1, op2;
  logic [31:0]       imm;

  logic [31:0]       rdata_a, rdata_b, alu_y, wdata;
  logic              we;
  logic [3:0]        alu_sel;

  assign op  = instr[OP_MSB:OP_LSB];
  assign op0 = instr[OP0_MSB:OP0_LSB];
  assign op1 = instr[OP1_MSB:OP1_LSB];
  assign op2 = instr[OP2_MSB:OP2_LSB];
  assign imm = {{16{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};

  integer_register u_regs (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (op1),
    .raddr_b (op2),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (we),
    .waddr   (op0),
    .wdata   (wdata)
  );

  alu_controller u_alu (
    .sel (alu_sel),
    .a   (rdata_a),
    .b   (rdata_b),
    .y   (alu_y)
  );

  led7seg #(.SCAN_DIV(SCAN_DIV)) u_disp (
    .clk    (clk),
    .reset  (reset),
    .value  ({dr[7:0], pc[7:0]}),
    .seg    (seg),
    .segsel (segsel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= '0;
      instr  <= '0;
      dr     <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      instr  <= instr_nxt;
      dr     <= dr_nxt;
      halted <= halted_nxt;
    end
  end

  always_comb begin
    alu_sel = ALU_NONE;
    case (op)
      OP_ADD:  alu_sel = ALU_ADD;
      OP_SUB:  alu_sel = ALU_SUB;
      default: alu_sel = ALU_NONE;
    endcase
  end

  // Halt freezes the core in FETCH with pc past END, so mem_addr stays put.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    instr_nxt  = instr;
    dr_nxt     = dr;
    halted_nxt = halted;
    we         = 1'b0;
    wdata      = '0;
    mem_addr   = (state == FETCH) ? pc : 16'h0000;

    if (!halted) begin
      case (state)
        FETCH: begin
          instr_nxt = mem_rdata;
          state_nxt = EXEC;
        end
        default: begin
          pc_nxt    = pc + 16'd1;
          state_nxt = FETCH;
          case (op)
            OP_LIMM16: begin
              we    = 1'b1;
              wdata = imm;
            end
            OP_CP: begin
              we    = 1'b1;
              wdata = rdata_a;
            end
            OP_ADD, OP_SUB: begin
              we    = 1'b1;
              wdata = alu_y;
            end
            OP_CPDR: dr_nxt = rdata_a;
            OP_END:  halted_nxt = 1'b1;
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osecpu_top.sv
// Directed bench for osecpu_top: small programs with hand-computed DR, pc and
// display expectations, scanning with SCAN_DIV=2.
module tb_osecpu_top;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  seg;
  logic [3:0]  segsel;
  logic        halted;
  logic [31:0] dr;

  logic [31:0] prog [256];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 16'd256) ? prog[mem_addr[7:0]] : 32'h0;

  osecpu_top #(.SCAN_DIV(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .seg       (seg),
    .segsel    (segsel),
    .halted    (halted),
    .dr        (dr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until_halt(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!halted && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halt"}, {31'b0, halted}, 32'd1);
  endtask

  // Phase is fixed by reset: after edge k the registered digit is ((k-1)/4)%4.
  task automatic check_scan(input string tag);
    logic [3:0] exp_sel;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_sel = 4'hF ^ (4'b0001 << (((k - 1) / 4) % 4));
      check(tag, {28'b0, segsel}, {28'b0, exp_sel});
    end
  endtask

  task automatic check_display(input logic [7:0] d3, input logic [7:0] d2,
                               input logic [7:0] d1, input logic [7:0] d0);
    logic [3:0] seen;
    seen = 4'h0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      case (segsel)
        4'b1110: begin seen[0] = 1'b1; check("disp_d0", {24'b0, seg}, {24'b0, d0}); end
        4'b1101: begin seen[1] = 1'b1; check("disp_d1", {24'b0, seg}, {24'b0, d1}); end
        4'b1011: begin seen[2] = 1'b1; check("disp_d2", {24'b0, seg}, {24'b0, d2}); end
        4'b0111: begin seen[3] = 1'b1; check("disp_d3", {24'b0, seg}, {24'b0, d3}); end
        default: check("disp_segsel", {28'b0, segsel}, 32'h0000_000E);
      endcase
    end
    check("disp_all_digits", {28'b0, seen}, 32'h0000_000F);
  endtask

  initial begin
    // LIMM16 / CPDR / END
    clear_prog();
    prog[0] = 32'h0204_0005;
    prog[1] = 32'hD300_1000;
    prog[2] = 32'hF000_0000;
    do_reset();
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_dr", dr, 32'h0);
    check("rst_mem_addr", {16'b0, mem_addr}, 32'h0);
    repeat (5) @(negedge clk);
    check("t1_not_halted_e5", {31'b0, halted}, 32'd0);
    @(negedge clk);
    check("t1_halted_e6", {31'b0, halted}, 32'd1);
    check("t1_dr_e6", dr, 32'h0000_0005);
    check("t1_pc_e6", {16'b0, mem_addr}, 32'd3);
    repeat (10) @(negedge clk);
    check("t1_pc_frozen", {16'b0, mem_addr}, 32'd3);
    check("t1_dr_frozen", dr, 32'h0000_0005);
    check_display(8'hC0, 8'h92, 8'hC0, 8'hB0);

    // ADD: R1=0x7FFF, R2=1, R3=R1+R2, DR=R3
    clear_prog();
    prog[0] = 32'h0204_7FFF;
    prog[1] = 32'h0208_0001;
    prog[2] = 32'h140C_1080;
    prog[3] = 32'hD300_3000;
    prog[4] = 32'hF000_0000;
    do_reset();
    run_until_halt("add", 40);
    check("add_dr", dr, 32'h0000_8000);
    check("add_pc", {16'b0, mem_addr}, 32'd5);

    // SUB wrap, then sign extension with bits [17:16] set
    clear_prog();
    prog[0] = 32'h0204_0000;
    prog[1] = 32'h0208_0001;
    prog[2] = 32'h150C_1080;
    prog[3] = 32'hD300_3000;
    prog[4] = 32'h0213_8000;
    prog[5] = 32'hD300_4000;
    prog[6] = 32'hF000_0000;
    do_reset();
    repeat (8) @(negedge clk);
    check("sub_wrap_dr", dr, 32'hFFFF_FFFF);
    run_until_halt("sub", 40);
    check("sext_dr", dr, 32'hFFFF_8000);

    // Reset after halt: R3 held 0xFFFFFFFF and must be cleared
    clear_prog();
    prog[0] = 32'hD300_3000;
    prog[1] = 32'hF000_0000;
    do_reset();
    check("rah_halted", {31'b0, halted}, 32'd0);
    check("rah_dr", dr, 32'h0);
    check("rah_mem_addr", {16'b0, mem_addr}, 32'h0);
    check_scan("scan_segsel");
    check("rah_halt_again", {31'b0, halted}, 32'd1);
    check("rah_reg_cleared", dr, 32'h0);
    check("rah_pc", {16'b0, mem_addr}, 32'd2);

    // CP and NOP
    clear_prog();
    prog[0] = 32'h0214_1234;
    prog[1] = 32'hD218_5000;
    prog[2] = 32'h0000_0000;
    prog[3] = 32'hD300_6000;
    prog[4] = 32'hF000_0000;
    do_reset();
    repeat (6) @(negedge clk);
    check("nop_pc_after", {16'b0, mem_addr}, 32'd3);
    run_until_halt("cp", 40);
    check("cp_dr", dr, 32'h0000_1234);
    check("cp_pc", {16'b0, mem_addr}, 32'd5);

    // Reset during EXEC of LIMM R7=0x55 must abandon the write
    clear_prog();
    prog[0] = 32'h021C_0055;
    prog[1] = 32'hD300_7000;
    prog[2] = 32'hF000_0000;
    do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_prog();
    prog[0] = 32'hD300_7000;
    prog[1] = 32'hF000_0000;
    reset = 1'b0;
    run_until_halt("midrst", 40);
    check("midrst_no_write", dr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/osecpu_top.md
Name: osecpu_top

Overview:
- Minimal OSECPU-style integer core: fetches 32-bit instructions from an external word-addressed program memory and executes a small integer subset.
- Built on a 64-entry integer register file, a combinational ALU, a 32-bit display register DR and a halt flag.
- Drives a 4-digit multiplexed 7-segment display showing {DR[7:0], pc[7:0]} in hex.
- Sits at the board top level between program memory and the display pins.

Parameters:
- SCAN_DIV, 16, log2 of clocks per display digit (digit advances every 2^SCAN_DIV clocks).

Ports:
- clk  input  1  single system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_addr  output  16  program memory word address.
- mem_rdata  input  32  instruction word; combinational read, valid in the same cycle as mem_addr.
- seg  output  8  segment drive, active-low: bit0=a … bit6=g, bit7=dp (dp always 1/off).
- segsel  output  4  digit select, active-low one-hot; segsel[0] is the rightmost digit.
- halted  output  1  high after END executes.
- dr  output  32  current DR value.

Behaviour:
- Reset (synchronous, highest priority): pc=0, state=FETCH, instr=0, DR=0, halted=0, all 64 registers=0, scan counter=0.
- Instruction fields:
  - op=[31:24], op0=[23:18], op1=[17:12], op2=[11:6].
  - imm=sign-extend([15:0]) to 32 bits; bits [17:16] are ignored for LIMM16.
- FSM (2 cycles per instruction):
  - FETCH: mem_addr=pc; instr<=mem_rdata; go to EXEC.
  - EXEC: mem_addr=0; execute instr; pc<=pc+1 (16-bit wrap, 0xFFFF→0); go to FETCH.
- Opcodes, all effects committed on the clock edge that ends EXEC:
  - 0x02 LIMM16: R[op0]=imm.
  - 0xD2 CP: R[op0]=R[op1].
  - 0x14 ADD: R[op0]=R[op1]+R[op2], mod 2^32.
  - 0x15 SUB: R[op0]=R[op1]-R[op2], mod 2^32.
  - 0xD3 CPDR: DR=R[op1].
  - 0xF0 END: halted<=1.
  - Any other opcode is a NOP; pc still advances.
- Register semantics:
  - Two combinational read ports, one write port.
  - A write issued in EXEC is visible to the next instruction's EXEC.
  - R0 is an ordinary writable register.
  - op0 may equal op1/op2; sources are read before the write.
- Halt:
  - When halted=1, pc, state, instr, DR and registers freeze.
  - pc holds END address+1; mem_addr holds its current value.
  - The display keeps scanning.
  - Only reset clears halted.
- Reset mid-instruction abandons the current instruction with no register/DR write.
- ALU ops (4-bit select): 4=ADD, 5=SUB, others output 0. Combinational, no flags.
- Display:
  - Free-running counter; digit index=counter[SCAN_DIV+1:SCAN_DIV].
  - Digit i shows nibble i of {DR[7:0],pc[7:0]}: digit0=pc[3:0], digit3=DR[7:4].
  - Hex font 0–F, active-low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - seg and segsel are registered and update together.

Decomposition:
- Package osecpu_pkg: opcode constants (OP_LIMM16, OP_CP, OP_ADD, OP_SUB, OP_CPDR, OP_END), ALU select constants, state enum {FETCH, EXEC}, field bit positions.
- Sub-modules: integer_register (64×32 register file), alu_controller (ALU), led7seg (display scanner/decoder).
- Decode/FSM lives in osecpu_top.

Test Plan:
- LIMM16/CPDR/END: program 0x02040005, 0xD3001000, 0xF0000000 from reset.
  - At the 6th clock edge: DR=0x5, halted=1, pc=3.
  - Further clocks leave pc=3.
  - Display digits 3..0 show C0, 92, C0, B0.
- ADD: LIMM R1=0x7FFF, LIMM R2=1, 0x140C1080 (R3=R1+R2), CPDR R3 → DR=0x00008000.
- SUB wrap and sign extension:
  - R1=0, R2=1, SUB R3=R1-R2 → DR=0xFFFFFFFF.
  - LIMM16 imm 0x8000 then CPDR → DR=0xFFFF8000.
- CP and NOP: LIMM R5=0x1234, CP R6=R5, opcode 0x00 word, CPDR R6 → DR=0x1234; pc increments through the NOP.
- Reset after halt: assert reset one cycle → pc=0, halted=0, DR=0, registers 0; fetch restarts at address 0 (mem_addr=0 in FETCH).
- Display scan (SCAN_DIV=2): segsel sequence 1110, 1101, 1011, 0111, each held 4 clocks, then repeats.
